// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock: supervisor state encoding and the
// keycode constants used by the code FSM.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2,
    ALARM   = 2'd3
  } lock_state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the supervisor's timed states; it holds at
// zero and reports expiry while the count is zero.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk5,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Supervisor above the keypad code FSM: owns the lock actuator, enforces the
// bad-attempt lockout via override, auto-relocks, and latches an alarm.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 150,
  parameter int RELOCK_CYCLES  = 50,
  parameter int MAX_LOCKOUTS   = 2
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic       lock_pulse,
  input  logic       attempt_pulse,
  input  logic       new_key,
  input  logic       alarm_ack,
  output logic       override,
  output logic       lock_open,
  output logic       alarm,
  output logic [3:0] bad_count,
  output logic [2:0] lockout_count
);

  localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RELOCK_LOAD  = TW'(RELOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

  lock_state_e state_q, state_d;
  logic [3:0]  bad_q, bad_d;
  logic [2:0]  lockouts_q, lockouts_d;
  logic        recover_q, recover_d;

  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_expired;

  logic [3:0] bad_inc;
  logic [2:0] lockouts_inc;
  logic       attempts_hit;
  logic       lockouts_hit;

  lock_timer #(.W(TW)) u_timer (
    .clk5       (clk5),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // Saturating increments; limits are compared against the post-increment value.
  assign bad_inc      = (bad_q == 4'hF) ? bad_q : bad_q + 4'd1;
  assign lockouts_inc = (lockouts_q == 3'h7) ? lockouts_q : lockouts_q + 3'd1;
  assign attempts_hit = (bad_inc == 4'(MAX_ATTEMPTS));
  assign lockouts_hit = (({1'b0, lockouts_q} + 4'd1) == 4'(MAX_LOCKOUTS));

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_q    <= LOCKED;
      bad_q      <= '0;
      lockouts_q <= '0;
      recover_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bad_q      <= bad_d;
      lockouts_q <= lockouts_d;
      recover_q  <= recover_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    lockouts_d  = lockouts_q;
    recover_d   = 1'b0;
    timer_load  = 1'b0;
    timer_value = RELOCK_LOAD;
    case (state_q)
      LOCKED: begin
        // lock_pulse has priority; a coincident attempt_pulse is dropped.
        if (lock_pulse) begin
          state_d     = OPEN;
          timer_load  = 1'b1;
          timer_value = RELOCK_LOAD;
          bad_d       = '0;
          lockouts_d  = '0;
        end else if (attempt_pulse) begin
          bad_d = bad_inc;
          if (attempts_hit) begin
            lockouts_d = lockouts_inc;
            if (lockouts_hit) begin
              state_d = ALARM;
            end else begin
              state_d     = LOCKOUT;
              timer_load  = 1'b1;
              timer_value = LOCKOUT_LOAD;
            end
          end
        end
      end
      OPEN: begin
        if (lock_pulse) begin
          state_d = LOCKED;
        end else if (new_key) begin
          timer_load  = 1'b1;
          timer_value = RELOCK_LOAD;
        end else if (timer_expired) begin
          state_d = LOCKED;
        end
      end
      LOCKOUT: begin
        if (timer_expired) begin
          state_d = LOCKED;
          bad_d   = '0;
        end
      end
      ALARM: begin
        if (alarm_ack) begin
          state_d    = LOCKED;
          bad_d      = '0;
          lockouts_d = '0;
        end
      end
      default: begin
        state_d   = LOCKED;
        recover_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    override      = (state_q == LOCKOUT) || (state_q == ALARM) || recover_q;
    lock_open     = (state_q == OPEN);
    alarm         = (state_q == ALARM);
    bad_count     = bad_q;
    lockout_count = lockouts_q;
  end

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor: relock timing, lockout, alarm escalation,
// acknowledge and reset, with hand-derived expectations.
module tb_lock_supervisor;

  logic       clk5 = 1'b0;
  logic       reset = 1'b1;
  logic       lock_pulse = 1'b0;
  logic       attempt_pulse = 1'b0;
  logic       new_key = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       override;
  logic       lock_open;
  logic       alarm;
  logic [3:0] bad_count;
  logic [2:0] lockout_count;

  int compared = 0;
  int mismatched = 0;

  lock_supervisor #(
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (150),
    .RELOCK_CYCLES  (50),
    .MAX_LOCKOUTS   (2)
  ) dut (
    .clk5          (clk5),
    .reset         (reset),
    .lock_pulse    (lock_pulse),
    .attempt_pulse (attempt_pulse),
    .new_key       (new_key),
    .alarm_ack     (alarm_ack),
    .override      (override),
    .lock_open     (lock_open),
    .alarm         (alarm),
    .bad_count     (bad_count),
    .lockout_count (lockout_count)
  );

  always #5 clk5 = ~clk5;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk5);
      #1;
    end
  endtask

  // Holds the given inputs across exactly one rising edge, then returns them low.
  task automatic applyStimulus(input logic lp, input logic ap, input logic nk,
                               input logic ack, input logic rst);
    lock_pulse    = lp;
    attempt_pulse = ap;
    new_key       = nk;
    alarm_ack     = ack;
    reset         = rst;
    @(posedge clk5);
    #1;
    lock_pulse    = 1'b0;
    attempt_pulse = 1'b0;
    new_key       = 1'b0;
    alarm_ack     = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ovr, input logic opn,
                          input logic alm, input logic [3:0] bad, input logic [2:0] lko);
    checkOutput({tag, ".override"}, {7'd0, override}, {7'd0, ovr});
    checkOutput({tag, ".lock_open"}, {7'd0, lock_open}, {7'd0, opn});
    checkOutput({tag, ".alarm"}, {7'd0, alarm}, {7'd0, alm});
    checkOutput({tag, ".bad_count"}, {4'd0, bad_count}, {4'd0, bad});
    checkOutput({tag, ".lockout_count"}, {5'd0, lockout_count}, {5'd0, lko});
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkAll("reset", 0, 0, 0, 4'd0, 3'd0);

    // A keypress while locked must not open anything.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("locked_key.lock_open", {7'd0, lock_open}, 8'd0);

    // Open at edge 0; timer holds 49..0 over edges 0..49, relock at edge 50.
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("open_entry", 0, 1, 0, 4'd0, 3'd0);
    idle(49);
    checkOutput("open_e49.lock_open", {7'd0, lock_open}, 8'd1);
    idle(1);
    checkOutput("open_e50.lock_open", {7'd0, lock_open}, 8'd0);

    // Key sampled at edge 40 reloads 49, so relock moves to edge 90.
    applyStimulus(1, 0, 0, 0, 0);
    idle(39);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("key_e40.lock_open", {7'd0, lock_open}, 8'd1);
    idle(49);
    checkOutput("key_e89.lock_open", {7'd0, lock_open}, 8'd1);
    idle(1);
    checkOutput("key_e90.lock_open", {7'd0, lock_open}, 8'd0);

    // Attempt ignored while open; manual relock at edge 60.
    applyStimulus(1, 0, 0, 0, 0);
    idle(39);
    applyStimulus(0, 0, 1, 0, 0);
    idle(18);
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("open_attempt", 0, 1, 0, 4'd0, 3'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("manual_relock.lock_open", {7'd0, lock_open}, 8'd0);

    // First lockout: override rises with the third bad code, lasts 150 edges.
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("bad1", {4'd0, bad_count}, 8'd1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("bad2", {4'd0, bad_count}, 8'd2);
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("lockout1_entry", 1, 0, 0, 4'd3, 3'd1);
    idle(10);
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("lockout1_attempt_ignored", 1, 0, 0, 4'd3, 3'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lockout1_lp_ignored.lock_open", {7'd0, lock_open}, 8'd0);
    idle(137);
    checkOutput("lockout1_e149.override", {7'd0, override}, 8'd1);
    idle(1);
    checkAll("lockout1_exit", 0, 0, 0, 4'd0, 3'd1);

    // A good code clears both counters, so the next lockout starts from zero.
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("pre_good.bad_count", {4'd0, bad_count}, 8'd2);
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("good_clears", 0, 1, 0, 4'd0, 3'd0);
    idle(50);
    checkOutput("good_relock.lock_open", {7'd0, lock_open}, 8'd0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("lockout2_entry", 1, 0, 0, 4'd3, 3'd1);
    idle(150);
    checkAll("lockout2_exit", 0, 0, 0, 4'd0, 3'd1);

    // Second lockout in a row escalates to a latched alarm.
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("alarm_entry", 1, 0, 1, 4'd3, 3'd2);
    idle(1000);
    checkAll("alarm_held", 1, 0, 1, 4'd3, 3'd2);
    applyStimulus(1, 1, 1, 0, 0);
    checkAll("alarm_pulses_ignored", 1, 0, 1, 4'd3, 3'd2);
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("alarm_ack", 0, 0, 0, 4'd0, 3'd0);

    // Reset mid-lockout, then coincident good and bad pulses.
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("lockout3_entry", 1, 0, 0, 4'd3, 3'd1);
    idle(20);
    applyStimulus(1, 1, 0, 0, 1);
    checkAll("mid_lockout_reset", 0, 0, 0, 4'd0, 3'd0);
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("lp_and_ap", 0, 1, 0, 4'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
